axi_id_remap_chan: RTL and testbench
====================================

// Module: axi_id_remap_chan
// PURPOSE
//  Allocating ID remapper for one AXI address/response channel pair (AW+B or AR+R); the wrapper
//  instantiates it twice. Any master ID maps to any free slave ID slot; the same master ID always
//  reuses its live slot, so same-ID order holds. No collisions while free slots remain.
//  Address path carries a built-in forward register slice. Response path is combinational.
// PARAMETERS
//  MID_WIDTH        8   master-side ID width
//  SID_WIDTH        2   slave-side ID width; must be < MID_WIDTH, else $fatal; 2**SID_WIDTH slots
//  ACTIVE_CNT_WIDTH 4   per-slot outstanding counter width; max 2**ACTIVE_CNT_WIDTH-1 in flight
//  PAYLOAD_WIDTH    64  opaque address-channel payload (addr/len/size/burst/... packed by wrapper)
// PORTS
//  clk            in   1        clock
//  rstn           in   1        reset; asynchronous, active-low
//  m_a_id         in   MID      master request ID
//  m_a_payload    in   PAYLOAD  master request payload
//  m_a_valid      in   1        master request valid
//  m_a_ready      out  1        master request ready
//  s_a_id         out  SID      remapped slave request ID (registered)
//  s_a_payload    out  PAYLOAD  slave request payload (registered)
//  s_a_valid      out  1        slave request valid (registered)
//  s_a_ready      in   1        slave request ready
//  s_rsp_id       in   SID      slave response ID
//  s_rsp_last     in   1        last beat of response (tie 1 for B channel)
//  s_rsp_valid    in   1        slave response valid
//  s_rsp_ready    out  1        = m_rsp_ready
//  m_rsp_id       out  MID      restored master ID = slot[s_rsp_id].mid
//  m_rsp_valid    out  1        = s_rsp_valid
//  m_rsp_ready    in   1        master response ready
// BEHAVIOUR
//  - Table: 2**SID_WIDTH slots {mid[MID-1:0], cnt[ACW-1:0]}; slot live iff cnt!=0. Reset: all 0.
//  - Lookup (from registered table state only): hit = live slot with mid==m_a_id (at most one).
//    hit & cnt!=max -> use that slot. hit & cnt==max -> stall. No hit -> lowest-index
//    free slot; none free -> stall (ID exhaustion).
//  - m_a_ready = slot_ok && (!s_a_valid || s_a_ready); 0 while rstn low. Independent of m_a_valid.
//  - Accept (m_a_valid&m_a_ready): output reg <= {slot, payload}, s_a_valid<=1 next cycle
//    (1-cycle latency, full throughput); slot.mid<=m_a_id, slot.cnt+1.
//  - s_a_valid drops after s_a_ready handshake unless a new accept same cycle. Output stable
//    while s_a_valid&!s_a_ready.
//  - Release: s_rsp_valid&s_rsp_ready&s_rsp_last -> slot[s_rsp_id].cnt-1. last=0 beats: no change.
//  - Accept and release on the same slot in the same cycle: cnt unchanged, mid rewritten (equal).
//  - Slot freed this cycle is not allocatable until next cycle (lookup uses registered cnt).
//  - Release on slot with cnt==0: protocol error; SVA assertion fires; cnt stays 0 (no wrap).
//  - Reset mid-operation: table cleared, s_a_valid<=0; in-flight transactions are lost.
//  - m_rsp_id/m_rsp_valid/s_rsp_ready purely combinational; wrapper adds slices if timing needs.
//  - Reset values: s_a_valid 0, s_a_id 0, s_a_payload 0, m_a_ready 0.
// TESTING
//  1. Reset, m_a_id=0xA5 valid -> m_a_ready=1, next cycle s_a_valid=1, s_a_id=0, payload matches.
//  2. Req 0xA5, 0xA5, 0x3C -> s_a_id 0,0,1; slot0.cnt=2; B on sid 0 -> m_rsp_id=0xA5, cnt=1.
//  3. Four distinct IDs outstanding, fifth 0x77 -> m_a_ready=0; release sid 2 -> 0x77 accepted
//     the following cycle on s_a_id=2.
//  4. 15 reqs on 0x11 -> 16th stalls; one last-beat on its slot -> 16th accepted, cnt stays 15.
//  5. R burst len 4 on sid 1: beats 1-3 (last=0) keep cnt; beat 4 frees; same-cycle new 0x11
//     on that slot -> cnt unchanged.
//  6. s_a_ready=0 for 5 cycles with s_a_valid=1 -> s_a_id/payload stable, m_a_ready=0; random
//     backpressure soak vs scoreboard: every m_rsp_id equals the issuing master ID, in order per ID.

Source files
------------

// File: rtl/axi_id_remap_chan.sv
// Allocating ID remapper for one AXI address/response channel pair.
// Master IDs are mapped onto a small table of slave ID slots; a master ID
// keeps its slot while it has transactions in flight, so same-ID ordering
// is preserved. Address path is a forward register slice; response path is
// combinational.
module axi_id_remap_chan #(
  parameter int MID_WIDTH        = 8,
  parameter int SID_WIDTH        = 2,
  parameter int ACTIVE_CNT_WIDTH = 4,
  parameter int PAYLOAD_WIDTH    = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [MID_WIDTH-1:0]     m_a_id,
  input  logic [PAYLOAD_WIDTH-1:0] m_a_payload,
  input  logic                     m_a_valid,
  output logic                     m_a_ready,
  output logic [SID_WIDTH-1:0]     s_a_id,
  output logic [PAYLOAD_WIDTH-1:0] s_a_payload,
  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  input  logic [SID_WIDTH-1:0]     s_rsp_id,
  input  logic                     s_rsp_last,
  input  logic                     s_rsp_valid,
  output logic                     s_rsp_ready,
  output logic [MID_WIDTH-1:0]     m_rsp_id,
  output logic                     m_rsp_valid,
  input  logic                     m_rsp_ready
);

  localparam int NUM_SLOTS = 2 ** SID_WIDTH;
  localparam logic [ACTIVE_CNT_WIDTH-1:0] CNT_MAX = '1;

  // Remapping only makes sense when the slave ID space is narrower.
  if (SID_WIDTH >= MID_WIDTH) begin : g_bad_width
    $fatal(1, "axi_id_remap_chan: SID_WIDTH must be smaller than MID_WIDTH");
  end

  logic [MID_WIDTH-1:0]        slot_mid [NUM_SLOTS];
  logic [ACTIVE_CNT_WIDTH-1:0] slot_cnt [NUM_SLOTS];

  logic                 hit;
  logic                 hit_full;
  logic                 free_found;
  logic [SID_WIDTH-1:0] hit_idx;
  logic [SID_WIDTH-1:0] free_idx;
  logic [SID_WIDTH-1:0] sel_idx;
  logic                 slot_ok;
  logic                 a_fire;
  logic                 rel_fire;
  logic [NUM_SLOTS-1:0] slot_inc;
  logic [NUM_SLOTS-1:0] slot_dec;

  // Slot lookup from registered table state: reuse a live slot for this ID,
  // otherwise take the lowest-index free slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_cnt[i] != '0 && slot_mid[i] == m_a_id) begin
        hit     = 1'b1;
        hit_idx = SID_WIDTH'(i);
      end
      if (slot_cnt[i] == '0 && !free_found) begin
        free_found = 1'b1;
        free_idx   = SID_WIDTH'(i);
      end
    end
    hit_full = hit && (slot_cnt[hit_idx] == CNT_MAX);
    sel_idx  = hit ? hit_idx : free_idx;
    slot_ok  = hit ? !hit_full : free_found;
  end

  assign m_a_ready = rstn && slot_ok && (!s_a_valid || s_a_ready);
  assign a_fire    = m_a_valid && m_a_ready;
  assign rel_fire  = s_rsp_valid && s_rsp_ready && s_rsp_last;

  // Per-slot increment/decrement requests; a release on an idle slot is
  // dropped so the counter never wraps.
  always_comb begin
    slot_inc = '0;
    slot_dec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_inc[i] = a_fire && (sel_idx == SID_WIDTH'(i));
      slot_dec[i] = rel_fire && (s_rsp_id == SID_WIDTH'(i)) && (slot_cnt[i] != '0);
    end
  end

  // Slot table update: accept claims/extends a slot, last response beat
  // releases one outstanding transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_mid[i] <= '0;
        slot_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_inc[i]) slot_mid[i] <= m_a_id;
        if (slot_inc[i] && !slot_dec[i])
          slot_cnt[i] <= slot_cnt[i] + ACTIVE_CNT_WIDTH'(1);
        else if (slot_dec[i] && !slot_inc[i])
          slot_cnt[i] <= slot_cnt[i] - ACTIVE_CNT_WIDTH'(1);
      end
    end
  end

  // Forward register slice on the address path; holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_a_valid   <= 1'b0;
      s_a_id      <= '0;
      s_a_payload <= '0;
    end else if (a_fire) begin
      s_a_valid   <= 1'b1;
      s_a_id      <= sel_idx;
      s_a_payload <= m_a_payload;
    end else if (s_a_ready) begin
      s_a_valid   <= 1'b0;
    end
  end

  assign m_rsp_id    = slot_mid[s_rsp_id];
  assign m_rsp_valid = s_rsp_valid;
  assign s_rsp_ready = m_rsp_ready;

`ifndef SYNTHESIS
  // A completing response must belong to a slot with something in flight.
  rel_on_idle_slot : assert property (@(posedge clk) disable iff (!rstn)
    rel_fire |-> (slot_cnt[s_rsp_id] != '0))
    else $error("axi_id_remap_chan: release on idle slot %0d", s_rsp_id);
`endif

endmodule

// File: tb/tb_axi_id_remap_chan.sv
// Directed and random checks of axi_id_remap_chan with a queue scoreboard:
// accepted requests are queued and matched against the slave-side output,
// issued transactions are queued per slave ID and matched against the
// restored master ID on responses.
module tb_axi_id_remap_chan;

  logic        clk;
  logic        rstn;
  logic [7:0]  m_a_id;
  logic [63:0] m_a_payload;
  logic        m_a_valid;
  logic        m_a_ready;
  logic [1:0]  s_a_id;
  logic [63:0] s_a_payload;
  logic        s_a_valid;
  logic        s_a_ready;
  logic [1:0]  s_rsp_id;
  logic        s_rsp_last;
  logic        s_rsp_valid;
  logic        s_rsp_ready;
  logic [7:0]  m_rsp_id;
  logic        m_rsp_valid;
  logic        m_rsp_ready;

  axi_id_remap_chan #(
    .MID_WIDTH(8), .SID_WIDTH(2), .ACTIVE_CNT_WIDTH(4), .PAYLOAD_WIDTH(64)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_a_id(m_a_id), .m_a_payload(m_a_payload), .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .s_a_id(s_a_id), .s_a_payload(s_a_payload), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_rsp_id(s_rsp_id), .s_rsp_last(s_rsp_last), .s_rsp_valid(s_rsp_valid),
    .s_rsp_ready(s_rsp_ready),
    .m_rsp_id(m_rsp_id), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mid;
    logic [63:0] pl;
    logic [1:0]  sid;
    bit          chk_sid;
  } req_t;

  typedef struct {
    logic [1:0] sid;
    logic [7:0] mid;
  } rsp_t;

  req_t       req_q[$];
  rsp_t       rsp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         acc_flag;
  logic [1:0] cur_exp_sid;
  bit         cur_sid_chk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has_pending(input logic [1:0] sid);
    foreach (rsp_q[k]) if (rsp_q[k].sid == sid) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample handshakes before the edge, update scoreboard, end on negedge.
  task automatic tick();
    int idx;
    req_t e;
    rsp_t r;
    #2;
    acc_flag = 1'b0;
    if (s_a_valid && s_a_ready) begin
      chk("sa_expected", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) begin
        e = req_q.pop_front();
        chk("s_a_payload", s_a_payload, e.pl);
        if (e.chk_sid) chk("s_a_id", 64'(s_a_id), 64'(e.sid));
        r.sid = s_a_id;
        r.mid = e.mid;
        rsp_q.push_back(r);
      end
    end
    if (s_rsp_valid && m_rsp_ready) begin
      idx = -1;
      for (int k = rsp_q.size() - 1; k >= 0; k--) if (rsp_q[k].sid == s_rsp_id) idx = k;
      chk("rsp_known", 64'(idx >= 0), 64'd1);
      if (idx >= 0) begin
        chk("m_rsp_id", 64'(m_rsp_id), 64'(rsp_q[idx].mid));
        if (s_rsp_last) rsp_q.delete(idx);
      end
    end
    if (m_a_valid && m_a_ready) begin
      e.mid = m_a_id;
      e.pl = m_a_payload;
      e.sid = cur_exp_sid;
      e.chk_sid = cur_sid_chk;
      req_q.push_back(e);
      acc_flag = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] id, input logic [63:0] pl,
                      input logic [1:0] sid, input bit c);
    m_a_valid = 1'b1;
    m_a_id = id;
    m_a_payload = pl;
    cur_exp_sid = sid;
    cur_sid_chk = c;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (acc_flag) break;
    end
    chk("send_accepted", 64'(acc_flag), 64'd1);
    m_a_valid = 1'b0;
  endtask

  task automatic idle_inputs();
    m_a_valid = 1'b0;
    m_a_id = '0;
    m_a_payload = '0;
    s_a_ready = 1'b1;
    s_rsp_valid = 1'b0;
    s_rsp_last = 1'b0;
    s_rsp_id = '0;
    m_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    m_a_valid = 1'b1;
    #1;
    chk("rst_m_a_ready", 64'(m_a_ready), 64'd0);
    chk("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    chk("rst_s_a_id", 64'(s_a_id), 64'd0);
    chk("rst_s_a_payload", s_a_payload, 64'd0);
    m_a_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_q.delete();
    rsp_q.delete();
    rstn = 1'b1;
  endtask

  task automatic respond(input logic [1:0] sid, input bit last);
    s_rsp_valid = 1'b1;
    s_rsp_id = sid;
    s_rsp_last = last;
    tick();
    s_rsp_valid = 1'b0;
    s_rsp_last = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    cur_exp_sid = '0;
    cur_sid_chk = 1'b0;
    acc_flag = 1'b0;
    #1;

    // 1: first request goes to slot 0 with one cycle latency
    do_reset();
    m_a_valid = 1'b1;
    m_a_id = 8'hA5;
    m_a_payload = 64'h0123_4567_89AB_CDEF;
    cur_exp_sid = 2'd0;
    cur_sid_chk = 1'b1;
    #1;
    chk("t1_m_a_ready", 64'(m_a_ready), 64'd1);
    tick();
    m_a_valid = 1'b0;
    chk("t1_s_a_valid", 64'(s_a_valid), 64'd1);
    chk("t1_s_a_id", 64'(s_a_id), 64'd0);
    chk("t1_s_a_payload", s_a_payload, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("t1_s_a_valid_drop", 64'(s_a_valid), 64'd0);

    // 2: same ID shares a slot; response restores master ID
    do_reset();
    send(8'hA5, 64'h2001, 2'd0, 1'b1);
    send(8'hA5, 64'h2002, 2'd0, 1'b1);
    send(8'h3C, 64'h2003, 2'd1, 1'b1);
    tick();
    chk("t2_cnt0", 64'(dut.slot_cnt[0]), 64'd2);
    s_rsp_valid = 1'b1;
    s_rsp_id = 2'd0;
    s_rsp_last = 1'b1;
    #1;
    chk("t2_m_rsp_id", 64'(m_rsp_id), 64'hA5);
    chk("t2_m_rsp_valid", 64'(m_rsp_valid), 64'd1);
    chk("t2_s_rsp_ready", 64'(s_rsp_ready), 64'd1);
    tick();
    s_rsp_valid = 1'b0;
    chk("t2_cnt0_after", 64'(dut.slot_cnt[0]), 64'd1);

    // 3: exhaustion, freed slot usable only on the following cycle
    do_reset();
    send(8'h01, 64'h3001, 2'd0, 1'b1);
    send(8'h02, 64'h3002, 2'd1, 1'b1);
    send(8'h03, 64'h3003, 2'd2, 1'b1);
    send(8'h04, 64'h3004, 2'd3, 1'b1);
    tick();
    m_a_valid = 1'b1;
    m_a_id = 8'h77;
    m_a_payload = 64'h3077;
    cur_exp_sid = 2'd2;
    cur_sid_chk = 1'b1;
    #1;
    chk("t3_exhausted", 64'(m_a_ready), 64'd0);
    respond(2'd2, 1'b1);
    chk("t3_not_same_cycle", 64'(acc_flag), 64'd0);
    tick();
    chk("t3_accept_next", 64'(acc_flag), 64'd1);
    m_a_valid = 1'b0;
    tick();

    // 4: per-slot counter saturation
    do_reset();
    for (int i = 0; i < 15; i++) send(8'h11, 64'h4000 + 64'(i), 2'd0, 1'b1);
    tick();
    chk("t4_cnt15", 64'(dut.slot_cnt[0]), 64'd15);
    m_a_valid = 1'b1;
    m_a_id = 8'h11;
    m_a_payload = 64'h4016;
    cur_exp_sid = 2'd0;
    cur_sid_chk = 1'b1;
    #1;
    chk("t4_stall16", 64'(m_a_ready), 64'd0);
    respond(2'd0, 1'b1);
    chk("t4_no_accept_yet", 64'(acc_flag), 64'd0);
    tick();
    chk("t4_accept16", 64'(acc_flag), 64'd1);
    m_a_valid = 1'b0;
    chk("t4_cnt_still15", 64'(dut.slot_cnt[0]), 64'd15);
    tick();

    // 5: burst on sid 1, last beat coincides with new accept on same slot
    do_reset();
    send(8'h22, 64'h5001, 2'd0, 1'b1);
    send(8'h11, 64'h5002, 2'd1, 1'b1);
    tick();
    for (int b = 0; b < 3; b++) begin
      respond(2'd1, 1'b0);
      chk("t5_cnt_midburst", 64'(dut.slot_cnt[1]), 64'd1);
    end
    m_a_valid = 1'b1;
    m_a_id = 8'h11;
    m_a_payload = 64'h5003;
    cur_exp_sid = 2'd1;
    cur_sid_chk = 1'b1;
    respond(2'd1, 1'b1);
    chk("t5_same_cycle_accept", 64'(acc_flag), 64'd1);
    m_a_valid = 1'b0;
    chk("t5_cnt_unchanged", 64'(dut.slot_cnt[1]), 64'd1);
    chk("t5_mid", 64'(dut.slot_mid[1]), 64'h11);
    tick();

    // 6: output stall holds the slice and blocks the master side
    do_reset();
    s_a_ready = 1'b0;
    send(8'h40, 64'hFEED_0040, 2'd0, 1'b1);
    m_a_valid = 1'b1;
    m_a_id = 8'h41;
    m_a_payload = 64'hFEED_0041;
    cur_exp_sid = 2'd1;
    cur_sid_chk = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_m_a_ready", 64'(m_a_ready), 64'd0);
      chk("t6_s_a_valid", 64'(s_a_valid), 64'd1);
      chk("t6_s_a_id", 64'(s_a_id), 64'd0);
      chk("t6_s_a_payload", s_a_payload, 64'hFEED_0040);
      tick();
    end
    s_a_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (acc_flag) break;
    end
    chk("t6_accept_after_stall", 64'(acc_flag), 64'd1);
    m_a_valid = 1'b0;

    // random backpressure soak
    cur_sid_chk = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!m_a_valid || acc_flag) begin
        m_a_valid = ($urandom_range(0, 3) != 0);
        m_a_id = 8'h10 + 8'($urandom_range(0, 5));
        m_a_payload = {$urandom, $urandom};
      end
      s_a_ready = ($urandom_range(0, 3) != 0);
      m_rsp_ready = ($urandom_range(0, 3) != 0);
      s_rsp_valid = 1'b0;
      s_rsp_last = 1'b0;
      s_rsp_id = 2'($urandom_range(0, 3));
      if (has_pending(s_rsp_id) && $urandom_range(0, 1) == 1) begin
        s_rsp_valid = 1'b1;
        s_rsp_last = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    // drain everything still outstanding
    m_a_valid = 1'b0;
    s_a_ready = 1'b1;
    m_rsp_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (rsp_q.size() == 0 && req_q.size() == 0 && !s_a_valid) break;
      s_rsp_valid = 1'b0;
      s_rsp_last = 1'b0;
      if (rsp_q.size() != 0) begin
        s_rsp_valid = 1'b1;
        s_rsp_id = rsp_q[0].sid;
        s_rsp_last = 1'b1;
      end
      tick();
    end
    s_rsp_valid = 1'b0;
    chk("drain_empty", 64'(rsp_q.size() + req_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) chk("drain_cnt_zero", 64'(dut.slot_cnt[i]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
